// File: rtl/mpu_pkg.sv
// rtl/mpu_pkg.sv - shared constants, types and states for the MPU sequencer
package mpu_pkg;

  localparam int MPU_DIM  = 5;
  localparam int ELEM_W   = 8;
  localparam int MATRIX_W = MPU_DIM * MPU_DIM * ELEM_W;

  typedef logic signed [ELEM_W-1:0]   integer_8_t;
  typedef logic signed [MATRIX_W-1:0] matrix_5x5_t;

  localparam logic [2:0] OP_ADD        = 3'd0;
  localparam logic [2:0] OP_SUB        = 3'd1;
  localparam logic [2:0] OP_SCALAR_MUL = 3'd2;
  localparam logic [2:0] OP_OPPOSITE   = 3'd3;
  localparam logic [2:0] OP_TRANSPOSE  = 3'd4;

  typedef logic [2:0] mpu_state_t;

  localparam mpu_state_t ST_IDLE    = 3'd0;
  localparam mpu_state_t ST_LOAD_A  = 3'd1;
  localparam mpu_state_t ST_LOAD_B  = 3'd2;
  localparam mpu_state_t ST_DRAIN   = 3'd3;
  localparam mpu_state_t ST_EXEC    = 3'd4;
  localparam mpu_state_t ST_CAPTURE = 3'd5;
  localparam mpu_state_t ST_STORE   = 3'd6;
  localparam mpu_state_t ST_DONE    = 3'd7;

  function automatic logic cmd_legal(input logic [2:0] op, input logic [7:0] size);
    return (op <= OP_TRANSPOSE) && (size >= 8'd1) && (size <= 8'(MPU_DIM));
  endfunction

endpackage

// File: rtl/mpu_index_counter.sv
// rtl/mpu_index_counter.sv - row-major r,c walker bounded by n, emits 5r+c offset
module mpu_index_counter
  import mpu_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       step,
  input  logic [2:0] size,
  output logic       last,
  output logic [4:0] offset
);

  logic [2:0] row;
  logic [2:0] col;
  logic [2:0] lim;

  assign lim    = size - 3'd1;
  assign last   = (row == lim) && (col == lim);
  assign offset = 5'(32'(row) * MPU_DIM + 32'(col));

  // Wraps to (0,0) after the last element so the next walk starts clean.
  always_ff @(posedge clock) begin
    if (!reset_n || start) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (last) begin
        row <= '0;
        col <= '0;
      end else if (col == lim) begin
        col <= '0;
        row <= row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end
  end

endmodule

// File: rtl/mpu_sequencer.sv
// rtl/mpu_sequencer.sv - command sequencer: fetch operands, run datapath, store result
module mpu_sequencer
  import mpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int BASE_A = 0,
  parameter int BASE_B = 25,
  parameter int BASE_R = 50
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [7:0]        cmd_size,
  input  integer_8_t        cmd_factor,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  integer_8_t        mem_rdata,
  output logic              mem_write,
  output integer_8_t        mem_wdata,
  output logic [2:0]        dp_operation,
  output matrix_5x5_t       dp_matrix_a,
  output matrix_5x5_t       dp_matrix_b,
  output logic [7:0]        dp_size,
  output integer_8_t        dp_factor,
  input  matrix_5x5_t       dp_result,
  output logic              busy,
  output logic              done,
  output logic              error
);

  mpu_state_t  state;
  logic [2:0]  op_q;
  logic [7:0]  size_q;
  integer_8_t  factor_q;
  logic        error_q;
  matrix_5x5_t mat_a;
  matrix_5x5_t mat_b;
  matrix_5x5_t result_q;
  logic        rd_pending;
  logic        rd_to_b;
  logic [4:0]  rd_idx;
  logic        accept;
  logic        idx_last;
  logic [4:0]  elem_idx;

  assign cmd_ready    = (state == ST_IDLE) && reset_n;
  assign accept       = cmd_valid && cmd_ready;
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign error        = error_q;
  assign mem_read     = (state == ST_LOAD_A) || (state == ST_LOAD_B);
  assign mem_write    = (state == ST_STORE);
  assign dp_operation = op_q;
  assign dp_size      = size_q;
  assign dp_factor    = factor_q;
  assign dp_matrix_a  = mat_a;
  assign dp_matrix_b  = mat_b;

  mpu_index_counter u_index (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (accept),
    .step    (mem_read || mem_write),
    .size    (size_q[2:0]),
    .last    (idx_last),
    .offset  (elem_idx)
  );

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_LOAD_A: mem_addr = ADDR_W'(BASE_A) + ADDR_W'(elem_idx);
      ST_LOAD_B: mem_addr = ADDR_W'(BASE_B) + ADDR_W'(elem_idx);
      ST_STORE: begin
        mem_addr  = ADDR_W'(BASE_R) + ADDR_W'(elem_idx);
        mem_wdata = result_q[{elem_idx, 3'b000} +: ELEM_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      size_q     <= '0;
      factor_q   <= '0;
      error_q    <= 1'b0;
      mat_a      <= '0;
      mat_b      <= '0;
      result_q   <= '0;
      rd_pending <= 1'b0;
      rd_to_b    <= 1'b0;
      rd_idx     <= '0;
    end else begin
      // Read data lands one cycle after its strobe, possibly in the next state.
      rd_pending <= mem_read;
      rd_to_b    <= (state == ST_LOAD_B);
      rd_idx     <= elem_idx;
      if (rd_pending) begin
        if (rd_to_b) mat_b[{rd_idx, 3'b000} +: ELEM_W] <= mem_rdata;
        else         mat_a[{rd_idx, 3'b000} +: ELEM_W] <= mem_rdata;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= cmd_op;
            size_q   <= cmd_size;
            factor_q <= cmd_factor;
            mat_a    <= '0;
            mat_b    <= '0;
            error_q  <= !cmd_legal(cmd_op, cmd_size);
            state    <= cmd_legal(cmd_op, cmd_size) ? ST_LOAD_A : ST_DONE;
          end
        end
        ST_LOAD_A: begin
          if (idx_last)
            state <= (op_q == OP_ADD || op_q == OP_SUB) ? ST_LOAD_B : ST_DRAIN;
        end
        ST_LOAD_B: if (idx_last) state <= ST_DRAIN;
        ST_DRAIN:  state <= ST_EXEC;
        ST_EXEC:   state <= ST_CAPTURE;
        ST_CAPTURE: begin
          result_q <= dp_result;
          state    <= ST_STORE;
        end
        ST_STORE:  if (idx_last) state <= ST_DONE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_sequencer.sv
// tb/tb_mpu_sequencer.sv - scoreboard bench with memory and datapath models
module tb_mpu_sequencer;
  import mpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_size;
  integer_8_t  cmd_factor;
  logic [7:0]  mem_addr;
  logic        mem_read;
  integer_8_t  mem_rdata = '0;
  logic        mem_write;
  integer_8_t  mem_wdata;
  logic [2:0]  dp_operation;
  matrix_5x5_t dp_matrix_a;
  matrix_5x5_t dp_matrix_b;
  logic [7:0]  dp_size;
  integer_8_t  dp_factor;
  matrix_5x5_t dp_result = '0;
  logic        busy;
  logic        done;
  logic        error;

  integer_8_t mem [0:255];
  int exp_rd[$];
  int exp_wa[$];
  int exp_wd[$];
  int n_cmp = 0;
  int n_bad = 0;
  int w_cnt = 0;

  always #5 clock = ~clock;

  mpu_sequencer dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_size(cmd_size), .cmd_factor(cmd_factor),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .mem_write(mem_write), .mem_wdata(mem_wdata),
    .dp_operation(dp_operation), .dp_matrix_a(dp_matrix_a), .dp_matrix_b(dp_matrix_b),
    .dp_size(dp_size), .dp_factor(dp_factor), .dp_result(dp_result),
    .busy(busy), .done(done), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic matrix_5x5_t dp_model(input logic [2:0] op, input integer_8_t f,
                                           input matrix_5x5_t a, input matrix_5x5_t b);
    matrix_5x5_t r;
    integer_8_t ea, eb;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        ea = a[8*(5*i+j) +: 8];
        eb = b[8*(5*i+j) +: 8];
        case (op)
          OP_ADD:        r[8*(5*i+j) +: 8] = ea + eb;
          OP_SUB:        r[8*(5*i+j) +: 8] = ea - eb;
          OP_SCALAR_MUL: r[8*(5*i+j) +: 8] = 8'(ea * f);
          OP_OPPOSITE:   r[8*(5*i+j) +: 8] = -ea;
          OP_TRANSPOSE:  r[8*(5*i+j) +: 8] = a[8*(5*j+i) +: 8];
          default:       r[8*(5*i+j) +: 8] = '0;
        endcase
      end
    end
    return r;
  endfunction

  always @(posedge clock) begin
    if (mem_read) mem_rdata <= mem[mem_addr];
    dp_result <= dp_model(dp_operation, dp_factor, dp_matrix_a, dp_matrix_b);
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_read && mem_write) chk("rw_exclusive", 32'(mem_write), 32'd0);
      if (mem_read) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", {24'b0, mem_addr}, 32'hffff_ffff);
        else chk("rd_addr", {24'b0, mem_addr}, 32'(exp_rd.pop_front()));
      end
      if (mem_write) begin
        w_cnt++;
        if (exp_wa.size() == 0) chk("wr_unexpected", {24'b0, mem_addr}, 32'hffff_ffff);
        else begin
          chk("wr_addr", {24'b0, mem_addr}, 32'(exp_wa.pop_front()));
          chk("wr_data", {24'b0, mem_wdata}, 32'(exp_wd.pop_front()) & 32'hff);
        end
      end
    end
  end

  task automatic push_expect(input int op, input int n, input int f);
    integer_8_t a, b, v;
    for (int r = 0; r < n; r++) for (int c = 0; c < n; c++) exp_rd.push_back(5*r + c);
    if (op < 2) for (int r = 0; r < n; r++) for (int c = 0; c < n; c++) exp_rd.push_back(25 + 5*r + c);
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        a = mem[5*r + c];
        b = mem[25 + 5*r + c];
        case (op)
          0: v = a + b;
          1: v = a - b;
          2: v = 8'(a * 8'(f));
          3: v = -a;
          default: v = mem[5*c + r];
        endcase
        exp_wa.push_back(50 + 5*r + c);
        exp_wd.push_back(int'(v));
      end
    end
  endtask

  task automatic start_cmd(input int op, input int n, input int f);
    if (op <= 4 && n >= 1 && n <= 5) push_expect(op, n, f);
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_op = 3'(op); cmd_size = 8'(n); cmd_factor = 8'(f);
    @(negedge clock);
    chk("cmd_ready_c0", 32'(cmd_ready), 32'd1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int op, input int n, input int f, input int exp_done);
    int k;
    logic illegal;
    illegal = !(op <= 4 && n >= 1 && n <= 5);
    start_cmd(op, n, f);
    k = 0;
    do begin
      @(negedge clock);
      k++;
      if (k == 1) begin
        chk("error_c1", 32'(error), 32'(illegal));
        chk("busy_c1", 32'(busy), 32'd1);
      end
    end while (!done && k < 400);
    chk("done_cycle", 32'(k), 32'(exp_done));
    chk("ready_in_done", 32'(cmd_ready), 32'd0);
    chk("error_at_done", 32'(error), 32'(illegal));
    chk("dp_operation", {29'b0, dp_operation}, 32'(op));
    @(negedge clock);
    chk("done_pulse", 32'(done), 32'd0);
    chk("ready_again", 32'(cmd_ready), 32'd1);
    chk("rd_left", 32'(exp_rd.size()), 32'd0);
    chk("wr_left", 32'(exp_wa.size()), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done;
    int w0;
    int k;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    for (int i = 0; i < 25; i++) mem[i] = 8'(i);
    for (int i = 25; i < 50; i++) mem[i] = 8'd1;
    reset_n = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd1; cmd_size = 8'd3; cmd_factor = 8'd5;
    repeat (3) begin
      @(negedge clock);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_done_error", {30'b0, done, error}, 32'd0);
    chk("rst_dp_op", {29'b0, dp_operation}, 32'd0);
    chk("rst_dp_size", {24'b0, dp_size}, 32'd0);
    chk("rst_dp_a", 32'(dp_matrix_a != '0), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1; cmd_valid = 1'b0;
    @(negedge clock);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);
    chk("idle_after_rst", 32'(busy), 32'd0);

    run_cmd(0, 5, 0, 79);

    mem[0] = 8'd1; mem[1] = 8'd2; mem[5] = 8'd3; mem[6] = 8'd4;
    run_cmd(4, 2, 0, 12);

    mem[0] = 8'd3;
    run_cmd(2, 3, -2, 22);
    repeat (3) @(negedge clock);
    chk("dp_factor_hold", {24'b0, dp_factor}, 32'h0000_00fe);

    run_cmd(6, 3, 0, 1);
    run_cmd(0, 0, 0, 1);
    run_cmd(1, 3, 0, 31);
    run_cmd(3, 5, 0, 54);

    w0 = w_cnt;
    start_cmd(0, 4, 0);
    k = 0;
    while (w_cnt < w0 + 3 && k < 200) begin
      @(negedge clock); #1;
      k++;
    end
    chk("abort_reached_store", 32'(w_cnt >= w0 + 3), 32'd1);
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(negedge clock);
    chk("wr_during_rst", 32'(mem_write), 32'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    @(negedge clock);
    chk("abort_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    seen_done = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen_done++;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    run_cmd(0, 4, 0, 52);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
